lfsr_demap: RTL and testbench

//  Inverse of the LFSR counter-mapper: takes an LFSR state (code) and returns the step count n
//  at which a SEED-initialised Fibonacci LFSR reaches that state (discrete log by linear search).

---
 rtl/lfsr_demap_pkg.sv | 22 ++
 rtl/lfsr_demap_if.sv | 23 ++
 rtl/lfsr_demap_core.sv | 30 +++
 rtl/lfsr_demap.sv | 116 +++++++++++
 tb/tb_lfsr_demap.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_demap_pkg.sv
// Shared types and helpers for the LFSR discrete-log search (lfsr_demap).
package lfsr_demap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int         DEFAULT_W    = 3;
  localparam logic [2:0] DEFAULT_TAPS = 3'b110;
  localparam logic [2:0] DEFAULT_SEED = 3'b001;

  // Fibonacci step on a zero-extended state; callers cast the result back to their width.
  function automatic logic [31:0] lfsr_step(input logic [31:0] sr, input logic [31:0] taps,
                                            input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return ((sr << 1) | {31'd0, ^(sr & taps)}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_demap_if.sv
// Request/result bundle between a requester and the lfsr_demap search engine.
interface lfsr_demap_if #(
  parameter int W = 3
) ();
  logic         start;
  logic [W-1:0] code;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] n_out;
  logic [W-1:0] sr;
  logic [W-1:0] counter;

  modport master (
    output start, code,
    input  busy, done, err, n_out, sr, counter
  );

  modport slave (
    input  start, code,
    output busy, done, err, n_out, sr, counter
  );
endinterface

// File: rtl/lfsr_demap_core.sv
// W-bit Fibonacci LFSR register: load forces SEED, step advances one state.
module lfsr_demap_core
  import lfsr_demap_pkg::*;
#(
  parameter int           W    = DEFAULT_W,
  parameter logic [W-1:0] TAPS = DEFAULT_TAPS,
  parameter logic [W-1:0] SEED = DEFAULT_SEED
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         step,
  output logic [W-1:0] sr
);

  logic [W-1:0] sr_next;

  assign sr_next = W'(lfsr_step(32'(sr), 32'(TAPS), W));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr <= SEED;
    end else if (load) begin
      sr <= SEED;
    end else if (step) begin
      sr <= sr_next;
    end
  end

endmodule

// File: rtl/lfsr_demap.sv
// LFSR demapper: linear search for the step count at which a SEED-started LFSR reaches code.
// Optional macro LFSR_DEMAP_START_SYNC_EN: start is asynchronous, synchronised and edge-detected.
module lfsr_demap
  import lfsr_demap_pkg::*;
#(
  parameter int           W    = DEFAULT_W,
  parameter logic [W-1:0] TAPS = DEFAULT_TAPS,
  parameter logic [W-1:0] SEED = DEFAULT_SEED
) (
  input  logic           clock,
  input  logic           reset_n,
  lfsr_demap_if.slave    bus
);

  // Largest counter value; reaching it without a match means the code is unreachable.
  localparam logic [W-1:0] LAST = W'((2 ** W) - 2);

  state_t       state;
  logic         start_evt;
  logic [W-1:0] code_q;
  logic [W-1:0] counter;
  logic [W-1:0] n_out;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] sr;
  logic         hit;
  logic         load;
  logic         step;

`ifdef LFSR_DEMAP_START_SYNC_EN
  logic s0;
  logic s1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= bus.start;
      s1 <= s0;
    end
  end

  assign start_evt = s0 & ~s1;
`else
  assign start_evt = bus.start;
`endif

  assign hit  = (sr == code_q);
  assign load = (state != SEARCH) && start_evt;
  assign step = (state == SEARCH) && !hit && (counter != LAST);

  lfsr_demap_core #(
    .W    (W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_core (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (load),
    .step    (step),
    .sr      (sr)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      code_q  <= '0;
      counter <= '0;
      n_out   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_evt) begin
            code_q  <= bus.code;
            counter <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            state   <= SEARCH;
          end
        end
        SEARCH: begin
          // A match wins over the bound check on the last compare.
          if (hit) begin
            n_out <= counter;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else if (counter == LAST) begin
            n_out <= '0;
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            counter <= counter + W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.err     = err;
  assign bus.n_out   = n_out;
  assign bus.sr      = sr;
  assign bus.counter = counter;

endmodule

// File: tb/tb_lfsr_demap.sv
// Randomised and directed bench for lfsr_demap against a step-table reference model.
module tb_lfsr_demap;

  localparam int W = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  lfsr_demap_if #(.W(W)) bus ();

  lfsr_demap #(
    .W    (W),
    .TAPS (3'b110),
    .SEED (3'b001)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // seq[i] is the LFSR state i steps after SEED.
  logic [2:0] seq [0:7];

  bit         m_act  = 1'b0;
  int         m_j    = 0;
  int         m_len  = 0;
  int         m_k    = 0;
  int         m_idx  = 0;
  logic       m_evt  = 1'b0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic       m_err  = 1'b0;
  logic [2:0] m_n    = 3'd0;
  logic [2:0] m_sr   = 3'b001;
  logic [2:0] m_cnt  = 3'd0;
  logic       h1     = 1'b0;
  logic       h2     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  function automatic int find_step(input logic [2:0] c);
    for (int i = 0; i < 7; i++) if (seq[i] == c) return i;
    return -1;
  endfunction

  // Reference model: outcome of a search is decided at its start from the step table.
  always @(posedge clock) begin
    if (!reset_n) begin
      m_act = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_n = 3'd0; m_sr = 3'b001; m_cnt = 3'd0; h1 = 1'b0; h2 = 1'b0;
    end else begin
`ifdef LFSR_DEMAP_START_SYNC_EN
      m_evt = h1 & ~h2;
      h2 = h1;
      h1 = bus.start;
`else
      m_evt = bus.start;
`endif
      if (m_act) begin
        m_j++;
        if (m_j == m_len) begin
          m_act  = 1'b0;
          m_busy = 1'b0;
          m_done = 1'b1;
          m_err  = (m_k < 0);
          m_idx  = (m_k < 0) ? 6 : m_k;
          m_n    = (m_k < 0) ? 3'd0 : 3'(m_k);
          m_cnt  = 3'(m_idx);
          m_sr   = seq[m_idx];
        end else begin
          m_cnt = 3'(m_j);
          m_sr  = seq[m_j];
        end
      end else if (m_evt) begin
        m_k    = find_step(bus.code);
        m_len  = (m_k < 0) ? 7 : m_k + 1;
        m_j    = 0;
        m_act  = 1'b1;
        m_busy = 1'b1;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_sr   = seq[0];
        m_cnt  = 3'd0;
      end
    end
    #1;
    check("busy",    32'(bus.busy),    32'(m_busy));
    check("done",    32'(bus.done),    32'(m_done));
    check("err",     32'(bus.err),     32'(m_err));
    check("n_out",   32'(bus.n_out),   32'(m_n));
    check("sr",      32'(bus.sr),      32'(m_sr));
    check("counter", 32'(bus.counter), 32'(m_cnt));
  end

  task automatic run(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_start(input logic [2:0] c);
    @(negedge clock);
    bus.code  = c;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  initial begin
    logic [2:0] s;
    bus.start = 1'b0;
    bus.code  = 3'd0;

    seq[0] = 3'b001;
    for (int i = 1; i < 8; i++) begin
      s = seq[i-1];
      seq[i] = 3'(((int'(s) * 2) % 8) + ($countones(s & 3'b110) % 2));
    end
    check("model_step2",   32'(seq[2]), 32'h5);
    check("model_step6",   32'(seq[6]), 32'h4);
    check("model_period7", 32'(seq[7]), 32'h1);

    run(3);
    reset_n = 1'b1;
    run(1);
    check("reset_busy", 32'(bus.busy),    32'h0);
    check("reset_done", 32'(bus.done),    32'h0);
    check("reset_sr",   32'(bus.sr),      32'h1);
    check("reset_cnt",  32'(bus.counter), 32'h0);

    do_start(3'b001); run(12);
    check("t1_n",    32'(bus.n_out), 32'h0);
    check("t1_err",  32'(bus.err),   32'h0);
    check("t1_done", 32'(bus.done),  32'h1);

    do_start(3'b101); run(12);
    check("t2_n101", 32'(bus.n_out), 32'h2);
    do_start(3'b100); run(12);
    check("t2_n100", 32'(bus.n_out), 32'h6);

    do_start(3'b000); run(12);
    check("t3_err",  32'(bus.err),     32'h1);
    check("t3_done", 32'(bus.done),    32'h1);
    check("t3_n",    32'(bus.n_out),   32'h0);
    check("t3_cnt",  32'(bus.counter), 32'h6);

    do_start(3'b100); run(2);
    do_start(3'b001); run(12);
    check("t4_ignored", 32'(bus.n_out), 32'h6);
    do_start(3'b011); run(12);
    check("t4_restart", 32'(bus.n_out), 32'h3);

    do_start(3'b110); run(3);
    reset_n = 1'b0;
    #1;
    check("t5_busy", 32'(bus.busy),    32'h0);
    check("t5_done", 32'(bus.done),    32'h0);
    check("t5_sr",   32'(bus.sr),      32'h1);
    check("t5_cnt",  32'(bus.counter), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    do_start(3'b110); run(12);
    check("t5_n", 32'(bus.n_out), 32'h5);

    @(negedge clock);
    bus.code  = 3'b011;
    bus.start = 1'b1;
`ifdef LFSR_DEMAP_START_SYNC_EN
    run(10);
`else
    run(2);
`endif
    bus.start = 1'b0;
    run(14);
    check("t6_n",    32'(bus.n_out), 32'h3);
    check("t6_busy", 32'(bus.busy),  32'h0);

    for (int it = 0; it < 60; it++) begin
      @(negedge clock);
      bus.code  = 3'($urandom_range(0, 7));
      bus.start = 1'b1;
      run($urandom_range(1, 3));
      bus.start = 1'b0;
      if ($urandom_range(0, 3) == 0) bus.code = 3'($urandom_range(0, 7));
      run($urandom_range(1, 10));
      if ($urandom_range(0, 14) == 0) begin
        reset_n = 1'b0;
        run(1);
        reset_n = 1'b1;
      end
    end
    run(14);

    for (int c = 1; c < 8; c++) begin
      do_start(3'(c)); run(12);
      check("sweep_n",   32'(bus.n_out), 32'(find_step(3'(c))));
      check("sweep_err", 32'(bus.err),   32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
